alu_op_sequencer: RTL and testbench

Initiator side of the ALU unit enable/flag interface. Accepts one operation at a time over a valid/ready request channel and decodes `alu_fun[3:2]` into a one-hot unit enable. It waits for the selected unit's registered result flag, then returns the result over a valid/ready response channel. It sits between the instruction front-end and the arithmetic, logic, compare and shift units, and supervises each unit with a timeout.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_unit_decode.sv | 13 +
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and defaults for the ALU sequencing slice.
package alu_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_unit_decode.sv
// Maps a unit select plus an issue strobe onto one-hot unit enables.
module alu_unit_decode (
  input  logic       issue,
  input  logic [1:0] unit,
  output logic [3:0] en
);

  always_comb begin
    en = '0;
    if (issue) en[unit] = 1'b1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time to the selected unit, waits for its flag
// (with timeout) and returns the result over a valid/ready response channel.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int Data_In_Width  = DATA_W_DEF,
  parameter int Timeout_Cycles = TIMEOUT_DEF
) (
  input  logic                     CLK_in,
  input  logic                     RST_in,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [Data_In_Width-1:0] req_A,
  input  logic [Data_In_Width-1:0] req_B,
  input  logic [3:0]               req_fun,
  output logic [Data_In_Width-1:0] A_out,
  output logic [Data_In_Width-1:0] B_out,
  output logic [3:0]               alu_fun_out,
  output logic                     arith_En,
  output logic                     logic_En,
  output logic                     cmp_En,
  output logic                     shift_En,
  input  logic [Data_In_Width-1:0] arith_out,
  input  logic [Data_In_Width-1:0] logic_out,
  input  logic [Data_In_Width-1:0] cmp_out,
  input  logic [Data_In_Width-1:0] shift_out,
  input  logic                     arith_flag,
  input  logic                     logic_flag,
  input  logic                     cmp_flag,
  input  logic                     shift_flag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [Data_In_Width-1:0] rsp_data,
  output logic [1:0]               rsp_unit,
  output logic                     rsp_err
);

  localparam int CNT_W = $clog2(Timeout_Cycles + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Timeout_Cycles);

  state_e                               state, state_nxt;
  logic [CNT_W-1:0]                     cnt;
  logic [1:0]                           sel_unit;
  logic [3:0]                           unit_flags;
  logic [3:0][Data_In_Width-1:0]        unit_outs;
  logic [3:0]                           en;
  logic                                 sel_flag;
  logic [Data_In_Width-1:0]             sel_out;

  assign sel_unit   = alu_fun_out[3:2];
  assign unit_flags = {shift_flag, cmp_flag, logic_flag, arith_flag};
  assign unit_outs  = {shift_out, cmp_out, logic_out, arith_out};
  // Only the unit we issued to is ever looked at; other flags are noise.
  assign sel_flag   = unit_flags[sel_unit];
  assign sel_out    = unit_outs[sel_unit];

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);

  alu_unit_decode u_dec (
    .issue (state == ST_ISSUE),
    .unit  (sel_unit),
    .en    (en)
  );

  assign arith_En = en[UNIT_ARITH];
  assign logic_En = en[UNIT_LOGIC];
  assign cmp_En   = en[UNIT_CMP];
  assign shift_En = en[UNIT_SHIFT];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (sel_flag || cnt == CNT_MAX) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_in or negedge RST_in) begin
    if (!RST_in) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      A_out       <= '0;
      B_out       <= '0;
      alu_fun_out <= '0;
      rsp_data    <= '0;
      rsp_unit    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (req_valid) begin
          A_out       <= req_A;
          B_out       <= req_B;
          alu_fun_out <= req_fun;
        end
        ST_ISSUE: cnt <= '0;
        // A flag on the final allowed cycle still beats the timeout.
        ST_WAIT: if (sel_flag) begin
          rsp_data <= sel_out;
          rsp_err  <= 1'b0;
          rsp_unit <= sel_unit;
        end else if (cnt == CNT_MAX) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
          rsp_unit <= sel_unit;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed checks for alu_op_sequencer against registered unit models with programmable latency.
module tb_alu_op_sequencer;

  localparam int W = 16;
  localparam int T = 8;

  logic          CLK_in = 1'b0;
  logic          RST_in;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]  req_A, req_B, A_out, B_out, rsp_data;
  logic [3:0]    req_fun, alu_fun_out;
  logic [1:0]    rsp_unit;
  logic          arith_En, logic_En, cmp_En, shift_En;
  logic          arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [W-1:0]  arith_out, logic_out, cmp_out, shift_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int multi_en = 0;

  // Unit models: lat 0 = never answers, lat L = flag L cycles after enable.
  int           lat [4];
  int           cd  [4];
  logic [3:0]   fl_m;
  logic [3:0]   spur;
  logic [W-1:0] res [4];
  logic [3:0]   en_v;

  always #5 CLK_in = ~CLK_in;

  alu_op_sequencer #(.Data_In_Width(W), .Timeout_Cycles(T)) dut (
    .CLK_in(CLK_in), .RST_in(RST_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_fun(req_fun),
    .A_out(A_out), .B_out(B_out), .alu_fun_out(alu_fun_out),
    .arith_En(arith_En), .logic_En(logic_En), .cmp_En(cmp_En), .shift_En(shift_En),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_unit(rsp_unit), .rsp_err(rsp_err)
  );

  assign en_v       = {shift_En, cmp_En, logic_En, arith_En};
  assign arith_flag = fl_m[0] | spur[0];
  assign logic_flag = fl_m[1] | spur[1];
  assign cmp_flag   = fl_m[2] | spur[2];
  assign shift_flag = fl_m[3] | spur[3];
  assign arith_out  = res[0];
  assign logic_out  = res[1];
  assign cmp_out    = res[2];
  assign shift_out  = res[3];

  function automatic logic [W-1:0] calc(int u, logic [W-1:0] a, logic [W-1:0] b);
    case (u)
      0: calc = a + b;
      1: calc = a & b;
      2: calc = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: calc = a >> 1;
    endcase
  endfunction

  always @(posedge CLK_in) begin
    for (int u = 0; u < 4; u++) begin
      fl_m[u] <= 1'b0;
      if (en_v[u]) begin
        res[u] <= calc(u, A_out, B_out);
        if (lat[u] == 1) fl_m[u] <= 1'b1;
        cd[u] <= (lat[u] > 1) ? lat[u] - 1 : 0;
      end else if (cd[u] == 1) begin
        fl_m[u] <= 1'b1;
        cd[u]   <= 0;
      end else if (cd[u] > 1) begin
        cd[u] <= cd[u] - 1;
      end
    end
  end

  always @(negedge CLK_in)
    if (RST_in === 1'b1 && $countones(en_v) > 1) multi_en <= multi_en + 1;

  task automatic step();
    @(posedge CLK_in); #1;
    cyc++;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (en_v !== 4'b0) begin errors++; $display("FAIL rst_enables got %b exp 0000", en_v); end
    checks++; if ({A_out, B_out, alu_fun_out} !== '0) begin errors++; $display("FAIL rst_operands got %h %h %h exp 0", A_out, B_out, alu_fun_out); end
    checks++; if ({rsp_data, rsp_unit, rsp_err} !== '0) begin errors++; $display("FAIL rst_rsp_fields got %h %h %b exp 0", rsp_data, rsp_unit, rsp_err); end
    @(negedge CLK_in); RST_in = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_release got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_shift();
    req_A = 16'h0010; req_B = 16'h0000; req_fun = 4'b1100; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    checks++; if (en_v !== 4'b1000) begin errors++; $display("FAIL shift_en_c1 got %b exp 1000", en_v); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL shift_ready_c1 got %b exp 0", req_ready); end
    checks++; if (A_out !== 16'h0010 || alu_fun_out !== 4'b1100) begin errors++; $display("FAIL shift_latch got %h %b exp 0010 1100", A_out, alu_fun_out); end
    step();
    checks++; if (en_v !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL shift_c2 got en %b valid %b exp 0000 0", en_v, rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || en_v !== 4'b0000) begin errors++; $display("FAIL shift_c3_valid got %b en %b exp 1 0000", rsp_valid, en_v); end
    checks++; if (rsp_data !== 16'h0008 || rsp_unit !== 2'd3 || rsp_err !== 1'b0) begin errors++; $display("FAIL shift_rsp got %h %0d %b exp 0008 3 0", rsp_data, rsp_unit, rsp_err); end
    step();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL shift_idle got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    req_A = 16'h0003; req_B = 16'h0004; req_fun = 4'b0010; req_valid = 1'b1; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_no_rsp got %b exp 1", rsp_valid); end
    // Second request held during back-pressure must not be taken.
    req_A = 16'h0055; req_fun = 4'b0100; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0007 || rsp_err !== 1'b0 || rsp_unit !== 2'd0)
        begin errors++; $display("FAIL bp_hold_%0d got %b %h %b %0d exp 1 0007 0 0", i, rsp_valid, rsp_data, rsp_err, rsp_unit); end
      checks++; if (req_ready !== 1'b0 || A_out !== 16'h0003) begin errors++; $display("FAIL bp_busy_%0d got ready %b A %h exp 0 0003", i, req_ready, A_out); end
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_timeout(input int l, input logic exp_err);
    int n = 0;
    lat[1] = l;
    req_A = 16'h00FF; req_B = 16'h0F0F; req_fun = 4'b0100; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    checks++; if (n !== T + 2) begin errors++; $display("FAIL to_latency_l%0d got %0d exp %0d", l, n, T + 2); end
    checks++; if (rsp_err !== exp_err || rsp_data !== (exp_err ? 16'h0000 : 16'h000F) || rsp_unit !== 2'd1)
      begin errors++; $display("FAIL to_rsp_l%0d got %b %h %0d exp %b %h 1", l, rsp_err, rsp_data, rsp_unit, exp_err, exp_err ? 16'h0000 : 16'h000F); end
    step();
    lat[1] = 1;
  endtask

  task automatic test_spurious();
    int n = 0;
    lat[3] = 3;
    req_A = 16'h1234; req_B = 16'h0001; req_fun = 4'b1101; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    spur = 4'b0101;
    while (!rsp_valid && n < 20) begin step(); n++; end
    spur = 4'b0000;
    checks++; if (n !== 4) begin errors++; $display("FAIL spur_latency got %0d exp 4", n); end
    checks++; if (rsp_data !== 16'h091A || rsp_unit !== 2'd3 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL spur_rsp got %h %0d %b exp 091a 3 0", rsp_data, rsp_unit, rsp_err); end
    step();
    lat[3] = 1;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    lat[0] = 0;
    req_A = 16'hAAAA; req_B = 16'h5555; req_fun = 4'b0011; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step();
    #2 RST_in = 1'b0;
    #1;
    checks++; if ({A_out, B_out, alu_fun_out} !== '0) begin errors++; $display("FAIL rmid_operands got %h %h %h exp 0", A_out, B_out, alu_fun_out); end
    checks++; if (en_v !== 4'b0 || rsp_valid !== 1'b0 || {rsp_data, rsp_unit, rsp_err} !== '0)
      begin errors++; $display("FAIL rmid_outputs got en %b valid %b rsp %h %0d %b exp 0", en_v, rsp_valid, rsp_data, rsp_unit, rsp_err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
    @(negedge CLK_in); RST_in = 1'b1;
    lat[0] = 1;
    for (int i = 0; i < T + 4; i++) begin step(); if (rsp_valid) seen++; end
    checks++; if (seen !== 0 || req_ready !== 1'b1) begin errors++; $display("FAIL rmid_stale got rsp %0d ready %b exp 0 1", seen, req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   fn [4];
    logic [W-1:0] a  [4];
    logic [W-1:0] b  [4];
    logic [W-1:0] ex [4];
    int last = 0;
    fn = '{4'b0000, 4'b0110, 4'b1001, 4'b1111};
    a  = '{16'h7FFF, 16'hF0F0, 16'hFFFE, 16'h8000};
    b  = '{16'h0001, 16'h3C3C, 16'h0001, 16'h0000};
    ex = '{16'h8000, 16'h3030, 16'h0001, 16'h4000};
    multi_en = 0;
    rsp_ready = 1'b1;
    req_A = a[0]; req_B = b[0]; req_fun = fn[0]; req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!rsp_valid && n < 20) begin step(); n++; end
      checks++; if (rsp_data !== ex[k] || rsp_unit !== fn[k][3:2] || rsp_err !== 1'b0)
        begin errors++; $display("FAIL b2b_rsp_%0d got %h %0d %b exp %h %0d 0", k, rsp_data, rsp_unit, rsp_err, ex[k], fn[k][3:2]); end
      if (k > 0) begin
        checks++; if (cyc - last !== 4) begin errors++; $display("FAIL b2b_gap_%0d got %0d exp 4", k, cyc - last); end
      end
      last = cyc;
      if (k < 3) begin req_A = a[k+1]; req_B = b[k+1]; req_fun = fn[k+1]; end
      else req_valid = 1'b0;
      step();
    end
    checks++; if (multi_en !== 0) begin errors++; $display("FAIL b2b_onehot got %0d multi-enable cycles exp 0", multi_en); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_in = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_A = '0; req_B = '0; req_fun = '0;
    spur = 4'b0;
    lat = '{1, 1, 1, 1};
    #12;
    test_reset();
    test_shift();
    test_backpressure();
    test_timeout(0, 1'b1);
    test_timeout(T + 2, 1'b1);
    test_timeout(T + 1, 1'b0);
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
